mips_int_ctrl: RTL and testbench



---
 rtl/mips_cp0_pkg.sv | 35 +++
 rtl/irq_edge_sync.sv | 53 +++++
 rtl/mips_int_ctrl.sv | 153 +++++++++++++++
 tb/tb_mips_int_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cp0_pkg.sv
// Shared CP0 definitions for the interrupt controller: register numbers,
// field positions, FSM states and the lowest-pending-line helper.
package mips_cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 10;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_EXC_LSB = 2;

    localparam int IRQ_MAX = 6;

    localparam logic [4:0] EXC_INT = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } int_state_e;

    // Line 0 has the highest priority.
    function automatic logic [2:0] lowest_irq(input logic [IRQ_MAX-1:0] hit);
        logic [2:0] id;
        id = '0;
        for (int i = IRQ_MAX - 1; i >= 0; i--) begin
            if (hit[i]) id = 3'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Rising-edge detector for the external interrupt lines, with an optional
// two-flop synchronizer in front when MIPS_INT_SYNC_EN is defined.
module irq_edge_sync #(
    parameter int N_IRQ = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_IRQ-1:0] i_irq,
    output logic [N_IRQ-1:0] o_edge
);

    logic [N_IRQ-1:0] line;
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] prev_d;

`ifdef MIPS_INT_SYNC_EN
    logic [N_IRQ-1:0] sync1_q;
    logic [N_IRQ-1:0] sync1_d;
    logic [N_IRQ-1:0] sync2_q;
    logic [N_IRQ-1:0] sync2_d;

    always_comb begin
        sync1_d = i_irq;
        sync2_d = sync1_q;
    end

    // Reset high so a line already asserted at reset release gives no edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign line = sync2_q;
`else
    assign line = i_irq;
`endif

    always_comb begin
        prev_d = line;
        o_edge = line & ~prev_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) prev_q <= '1;
        else       prev_q <= prev_d;
    end

endmodule

// File: rtl/mips_int_ctrl.sv
// Interrupt controller plus Status/Cause/EPC for the single-cycle MIPS core.
// Define MIPS_INT_SYNC_EN to synchronize i_irq (see irq_edge_sync).
//   state      | meaning
//   ST_IDLE    | nothing pending and enabled
//   ST_REQ     | o_int_req high, waiting for the core to take it
//   ST_SERVICE | handler running (EXL set), waiting for ERET
module mips_int_ctrl
    import mips_cp0_pkg::*;
#(
    parameter int          N_IRQ       = 6,
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0180
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic [31:0]      i_pc,
    input  logic             i_int_ack,
    input  logic             i_eret,
    input  logic             i_cp0_we,
    input  logic [4:0]       i_cp0_addr,
    input  logic [31:0]      i_cp0_wdata,
    output logic [31:0]      o_cp0_rdata,
    output logic             o_int_req,
    output logic [31:0]      o_vector,
    output logic [31:0]      o_epc,
    output logic [2:0]       o_irq_id
);

    logic [N_IRQ-1:0] irq_edge;

    int_state_e       state_q,   state_d;
    logic             ie_q,      ie_d;
    logic             exl_q,     exl_d;
    logic [N_IRQ-1:0] im_q,      im_d;
    logic [N_IRQ-1:0] ip_q,      ip_d;
    logic [31:0]      epc_q,     epc_d;
    logic [2:0]       irq_id_q,  irq_id_d;
    logic             int_req_q, int_req_d;

    logic                 wr_status, wr_cause, wr_epc;
    logic                 pend;
    logic [IRQ_MAX-1:0]   hit_ext;
    logic [31:0]          status_word, cause_word;

    irq_edge_sync #(.N_IRQ(N_IRQ)) u_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_irq  (i_irq),
        .o_edge (irq_edge)
    );

    always_comb begin
        hit_ext              = '0;
        hit_ext[N_IRQ-1:0]   = ip_q & im_q;
    end

    assign pend      = ie_q & ~exl_q & (|(ip_q & im_q));
    assign wr_status = i_cp0_we && (i_cp0_addr == CP0_STATUS);
    assign wr_cause  = i_cp0_we && (i_cp0_addr == CP0_CAUSE);
    assign wr_epc    = i_cp0_we && (i_cp0_addr == CP0_EPC);

    always_comb begin
        state_d  = state_q;
        ie_d     = ie_q;
        exl_d    = exl_q;
        im_d     = im_q;
        epc_d    = epc_q;
        irq_id_d = irq_id_q;

        // A fresh edge beats a W1C of the same bit.
        ip_d = wr_cause ? (ip_q & ~i_cp0_wdata[CAUSE_IP_LSB +: N_IRQ]) : ip_q;
        ip_d = ip_d | irq_edge;

        if (wr_status) begin
            ie_d  = i_cp0_wdata[STATUS_IE];
            exl_d = i_cp0_wdata[STATUS_EXL];
            im_d  = i_cp0_wdata[STATUS_IM_LSB +: N_IRQ];
        end
        if (wr_epc) epc_d = i_cp0_wdata;

        // FSM updates come last so they override a coincident MTC0.
        case (state_q)
            ST_IDLE: begin
                if (pend) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (i_int_ack) begin
                    state_d  = ST_SERVICE;
                    epc_d    = i_pc;
                    exl_d    = 1'b1;
                    irq_id_d = lowest_irq(hit_ext);
                end else if (!pend) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (i_eret) begin
                    state_d = ST_IDLE;
                    exl_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        int_req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            im_q      <= '0;
            ip_q      <= '0;
            epc_q     <= '0;
            irq_id_q  <= '0;
            int_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            im_q      <= im_d;
            ip_q      <= ip_d;
            epc_q     <= epc_d;
            irq_id_q  <= irq_id_d;
            int_req_q <= int_req_d;
        end
    end

    always_comb begin
        status_word                              = '0;
        status_word[STATUS_IE]                   = ie_q;
        status_word[STATUS_EXL]                  = exl_q;
        status_word[STATUS_IM_LSB +: N_IRQ]      = im_q;

        cause_word                               = '0;
        cause_word[CAUSE_IP_LSB +: N_IRQ]        = ip_q;
        cause_word[CAUSE_EXC_LSB +: 5]           = EXC_INT;

        case (i_cp0_addr)
            CP0_STATUS: o_cp0_rdata = status_word;
            CP0_CAUSE:  o_cp0_rdata = cause_word;
            CP0_EPC:    o_cp0_rdata = epc_q;
            default:    o_cp0_rdata = '0;
        endcase
    end

    assign o_int_req = int_req_q;
    assign o_vector  = VECTOR_ADDR;
    assign o_epc     = epc_q;
    assign o_irq_id  = irq_id_q;

endmodule

// File: tb/tb_mips_int_ctrl.sv
// Bench for mips_int_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the CP0 rules.
module tb_mips_int_ctrl;

    localparam int          N   = 6;
    localparam logic [31:0] VEC = 32'h0000_0180;
`ifdef MIPS_INT_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [N-1:0]  i_irq;
    logic [31:0]   i_pc;
    logic          i_int_ack;
    logic          i_eret;
    logic          i_cp0_we;
    logic [4:0]    i_cp0_addr;
    logic [31:0]   i_cp0_wdata;
    logic [31:0]   o_cp0_rdata;
    logic          o_int_req;
    logic [31:0]   o_vector;
    logic [31:0]   o_epc;
    logic [2:0]    o_irq_id;

    always #5 i_clk = ~i_clk;

    mips_int_ctrl #(.N_IRQ(N), .VECTOR_ADDR(VEC)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_irq       (i_irq),
        .i_pc        (i_pc),
        .i_int_ack   (i_int_ack),
        .i_eret      (i_eret),
        .i_cp0_we    (i_cp0_we),
        .i_cp0_addr  (i_cp0_addr),
        .i_cp0_wdata (i_cp0_wdata),
        .o_cp0_rdata (o_cp0_rdata),
        .o_int_req   (o_int_req),
        .o_vector    (o_vector),
        .o_epc       (o_epc),
        .o_irq_id    (o_irq_id)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural registers plus "requesting"/"in handler" flags.
    bit [N-1:0] m_ip, m_im, m_prev, m_s1, m_s2;
    bit         m_ie, m_exl, m_req, m_svc;
    bit [31:0]  m_epc;
    bit [2:0]   m_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return 32'(m_im) * 1024 + 32'(m_exl) * 2 + 32'(m_ie);
            5'd13:   return 32'(m_ip) * 1024;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_ip = '0; m_im = '0; m_ie = 0; m_exl = 0; m_req = 0; m_svc = 0;
        m_epc = '0; m_id = '0;
        m_prev = '1; m_s1 = '1; m_s2 = '1;
    endtask

    task automatic model_step();
        bit [N-1:0] line, rise, hit, nip, nim;
        bit         pend, nie, nexl, nreq, nsvc;
        bit [31:0]  nepc;
        bit [2:0]   nid;
        bit         found;
`ifdef MIPS_INT_SYNC_EN
        line = m_s2;
`else
        line = i_irq;
`endif
        rise = line & ~m_prev;
        hit  = m_ip & m_im;
        pend = m_ie && !m_exl && (hit != 0);
        nip = m_ip; nim = m_im; nie = m_ie; nexl = m_exl;
        nepc = m_epc; nid = m_id; nreq = m_req; nsvc = m_svc;
        if (i_cp0_we && i_cp0_addr == 5'd13) nip = nip & ~i_cp0_wdata[10 +: N];
        nip = nip | rise;
        if (i_cp0_we && i_cp0_addr == 5'd12) begin
            nie = i_cp0_wdata[0]; nexl = i_cp0_wdata[1]; nim = i_cp0_wdata[10 +: N];
        end
        if (i_cp0_we && i_cp0_addr == 5'd14) nepc = i_cp0_wdata;
        if (m_req) begin
            if (i_int_ack) begin
                nreq = 0; nsvc = 1; nepc = i_pc; nexl = 1;
                found = 0; nid = 0;
                for (int i = 0; i < N; i++) begin
                    if (hit[i] && !found) begin nid = 3'(i); found = 1; end
                end
            end else if (!pend) begin
                nreq = 0;
            end
        end else if (m_svc) begin
            if (i_eret) begin nsvc = 0; nexl = 0; end
        end else if (pend) begin
            nreq = 1;
        end
        m_s2 = m_s1; m_s1 = i_irq; m_prev = line;
        m_ip = nip; m_im = nim; m_ie = nie; m_exl = nexl;
        m_epc = nepc; m_id = nid; m_req = nreq; m_svc = nsvc;
    endtask

    task automatic tick();
        if (i_rst) model_reset();
        else       model_step();
        @(posedge i_clk);
        #1;
        check("int_req", 32'(o_int_req), 32'(m_req));
        check("epc",     o_epc,          m_epc);
        check("irq_id",  32'(o_irq_id),  32'(m_id));
        check("vector",  o_vector,       VEC);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        i_cp0_addr = a;
        #1;
        v = o_cp0_rdata;
    endtask

    task automatic cp0_write(input logic [4:0] a, input logic [31:0] d);
        i_cp0_we = 1; i_cp0_addr = a; i_cp0_wdata = d;
        tick();
        i_cp0_we = 0;
    endtask

    task automatic wait_req(output int cycles);
        cycles = 0;
        while (!o_int_req && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        logic [31:0] v;
        int          cnt;

        i_rst = 1; i_irq = '0; i_irq[0] = 1'b1; i_pc = '0; i_int_ack = 0; i_eret = 0;
        i_cp0_we = 0; i_cp0_addr = '0; i_cp0_wdata = '0;
        tick(); tick();
        i_rst = 0;
        repeat (3) tick();

        // Line held high across reset release gives no edge.
        check("rst_int_req", 32'(o_int_req), 32'h0);
        rd(5'd12, v); check("rst_status", v, 32'h0);
        rd(5'd13, v); check("rst_cause",  v, 32'h0);
        rd(5'd14, v); check("rst_epc",    v, 32'h0);
        i_irq = '0;
        tick();

        // Basic request / ack on line 0.
        cp0_write(5'd12, 32'h0000_0401);
        rd(5'd12, v); check("status_wr", v, 32'h0000_0401);
        i_irq[0] = 1'b1;
        cnt = 0;
        while (!o_int_req && cnt < 20) begin
            tick();
            cnt++;
            i_irq[0] = 1'b0;
        end
        check("req_latency", 32'(cnt), 32'(LAT));
        i_pc = 32'h0000_0040; i_int_ack = 1;
        tick();
        i_int_ack = 0;
        check("ack_epc", o_epc, 32'h0000_0040);
        check("ack_id",  32'(o_irq_id), 32'h0);
        check("ack_req", 32'(o_int_req), 32'h0);
        rd(5'd12, v); check("ack_status", v, 32'h0000_0403);
        rd(5'd13, v); check("ack_cause",  v, 32'h0000_0400);

        // Clear, return, and confirm no re-request.
        cp0_write(5'd13, 32'h0000_0400);
        i_eret = 1; tick(); i_eret = 0;
        rd(5'd12, v); check("eret_status", v, 32'h0000_0401);
        repeat (3) tick();
        check("eret_no_req", 32'(o_int_req), 32'h0);
        check("eret_epc", o_epc, 32'h0000_0040);

        // Simultaneous edges on lines 1 and 2: lowest wins, other stays pending.
        cp0_write(5'd12, 32'h0000_1801);
        i_irq = 6'b000110; tick(); i_irq = '0;
        wait_req(cnt);
        check("two_req", 32'(o_int_req), 32'h1);
        i_pc = 32'h0000_0100; i_int_ack = 1; tick(); i_int_ack = 0;
        check("two_id", 32'(o_irq_id), 32'h1);
        rd(5'd13, v); check("two_cause", v, 32'h0000_1800);
        cp0_write(5'd13, 32'h0000_0800);
        i_eret = 1; tick(); i_eret = 0;
        wait_req(cnt);
        check("rereq", 32'(o_int_req), 32'h1);
        i_pc = 32'h0000_0200; i_int_ack = 1; tick(); i_int_ack = 0;
        check("rereq_id", 32'(o_irq_id), 32'h2);
        cp0_write(5'd13, 32'h0000_1000);
        i_eret = 1; tick(); i_eret = 0;

        // Request withdrawn by IE=0; a late ack must be ignored.
        cp0_write(5'd12, 32'h0000_2001);
        i_irq[3] = 1'b1; tick(); i_irq[3] = 1'b0;
        wait_req(cnt);
        check("ie_req", 32'(o_int_req), 32'h1);
        cp0_write(5'd12, 32'h0000_2000);
        tick();
        check("ie_drop", 32'(o_int_req), 32'h0);
        i_pc = 32'h0000_1234; i_int_ack = 1; tick(); i_int_ack = 0;
        check("late_ack_epc", o_epc, 32'h0000_0200);
        rd(5'd12, v); check("late_ack_status", v, 32'h0000_2000);
        rd(5'd13, v); check("late_ack_cause",  v, 32'h0000_2000);
        cp0_write(5'd13, 32'h0000_2000);

        // W1C of IP0 coincident with a new edge on line 0.
        i_irq[0] = 1'b1; tick(); i_irq[0] = 1'b0;
        repeat (LAT) tick();
        rd(5'd13, v); check("ip0_set", v, 32'h0000_0400);
        i_irq[0] = 1'b1;
        repeat (LAT - 2) tick();
        cp0_write(5'd13, 32'h0000_0400);
        rd(5'd13, v); check("w1c_vs_edge", v, 32'h0000_0400);
        cp0_write(5'd13, 32'h0000_0400);
        rd(5'd13, v); check("w1c_plain", v, 32'h0);
        i_irq = '0;
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            int r;
            i_irq       = i_irq ^ N'($urandom & $urandom & $urandom);
            i_pc        = $urandom;
            i_cp0_we    = ($urandom_range(0, 7) == 0);
            r           = $urandom_range(0, 7);
            i_cp0_addr  = (r < 3) ? 5'd12 : (r < 5) ? 5'd13 : (r == 5) ? 5'd14 : 5'($urandom);
            i_cp0_wdata = $urandom;
            if (i_cp0_addr == 5'd12 && $urandom_range(0, 3) != 0) begin
                i_cp0_wdata[0] = 1'b1;
                i_cp0_wdata[1] = 1'b0;
            end
            i_int_ack = o_int_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            i_eret    = ($urandom_range(0, 5) == 0);
            i_rst     = ($urandom_range(0, 199) == 0);
            #1;
            check("rand_rdata", o_cp0_rdata, m_read(i_cp0_addr));
            tick();
        end
        i_rst = 0; i_cp0_we = 0; i_int_ack = 0; i_eret = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
